arbitro_alu: RTL and testbench
==============================

Name: arbitro_alu

Overview:
Shares one unidad_logico_aritmetica instance between two requesters, requester 0 and requester 1 (e.g. decode path and address-generation path). The block arbitrates round-robin, latches operands and opcode, and drives the ALU from registers. It captures the ALU result and, when requested, the NZCV flags, then returns the result to the winning requester over a valid/ready handshake. It sits between the requesters and the combinational ALU; the ALU itself is instantiated outside this block.

Parameters:
ANCHO, 32, datapath width of operands and result; must match the ALU instance width.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation pending.
req0_ready  out  1  block accepts requester 0 this cycle.
req0_a  in  ANCHO  operand A, requester 0.
req0_b  in  ANCHO  operand B, requester 0.
req0_op  in  4  ALUControl code, requester 0.
req0_s  in  1  update flags on completion, requester 0.
req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_s  same as requester 0, for requester 1.
resp0_valid  out  1  result available for requester 0.
resp0_ready  in  1  requester 0 consumes result.
resp0_resultado  out  ANCHO  result for requester 0.
resp1_valid, resp1_ready, resp1_resultado  same as requester 0, for requester 1.
alu_a  out  ANCHO  to ALU numero1.
alu_b  out  ANCHO  to ALU numero2.
alu_control  out  4  to ALU ALUControl.
alu_resultado  in  ANCHO  from ALU resultado.
alu_n, alu_z, alu_v, alu_c  in  1 each  from ALU flagNegativo, flagCero, flagOverflow, flagCarry.
flags  out  4  registered {N,Z,C,V}.
ocupado  out  1  high in any state other than LIBRE.

Behaviour:
- FSM states: LIBRE, EJECUTAR, RESPONDER.
- LIBRE:
  - Grant is combinational. If exactly one reqX_valid is high, that requester wins. If both are high, the winner is the requester not granted last; the pointer is set at reset so requester 0 wins first.
  - reqX_ready is high only for the winner and only in LIBRE. All reqX_ready are 0 in other states and while rst is high.
  - Handshake (valid & ready) on a rising edge: latch a, b, op, s and the winner id into registers, update the pointer to the winner, and go to EJECUTAR.
- EJECUTAR: lasts exactly one cycle. alu_a, alu_b and alu_control are always driven from the operand registers, so the ALU inputs are stable the whole cycle. On the exiting edge:
  - resultado register <= alu_resultado.
  - If s is set, flags <= {alu_n, alu_z, alu_c, alu_v}; otherwise flags are held.
  - Go to RESPONDER.
- RESPONDER:
  - respX_valid is high only for the latched id. respX_resultado shows the result register; the other resp_resultado shows the same register but its valid is 0.
  - Result and valid stay stable until respX_ready is high on an edge; on that edge go to LIBRE.
- Latency: accept at edge t; respX_valid is high from edge t+1. With ready tied high, the response handshake is at edge t+2. The next accept is possible at edge t+3, so peak throughput is 1 op per 3 cycles.
- Opcodes are passed through unchanged, including codes the ALU leaves unused. The result is whatever the ALU returns, and flags update per s.
- Dropping reqX_valid without a handshake is legal and has no effect.
- Operands presented while not in LIBRE are ignored and not queued.
- Reset (asynchronous, any state): state goes to LIBRE, pointer so requester 0 wins first. Operand registers, opcode, result and flags clear to 0, so alu_a, alu_b and alu_control read 0. All valid and ready outputs are 0 and ocupado is 0. An in-flight operation is discarded with no response.

Test Plan:
1. ANCHO=4; req0 AND (op 0000), a=1010, b=0110, s=0 -> req0_ready=1 in LIBRE; resp0_valid one edge after accept; resp0_resultado=0010; flags stay 0000; resp1_valid stays 0.
2. req1 ADD (op 1000), a=1010, b=0110, s=1 -> resp1_resultado=0000; flags=0110 (N0 Z1 C1 V0).
3. Both valid right after reset with different ops, held high -> requester 0 served first, then requester 1. Re-present both again -> requester 0 wins again (strict alternation); no ready pulses while ocupado=1.
4. req0 SUB (op 1001), a=1010, b=0110, s=0, with resp0_ready low for 5 cycles -> resp0_valid and resp0_resultado=0100 held; alu_a, alu_b and alu_control stable; req1_ready=0 throughout; flags unchanged from scenario 2.
5. req0 with op 1010 (A right shift arithmetic), a=1010, s=1 -> resp0_resultado=1101; flags N=1, Z=0.
6. Assert rst during EJECUTAR -> all outputs clear immediately (asynchronously) to 0; no resp valid after release; the next simultaneous request grants requester 0.

Source files
------------

// File: rtl/arbitro_alu.sv
// Round-robin arbiter that shares one external combinational ALU between two
// requesters, latching operands, executing for one cycle and returning the result.
module arbitro_alu #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ANCHO-1:0] req0_a,
  input  logic [ANCHO-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ANCHO-1:0] req1_a,
  input  logic [ANCHO-1:0] req1_b,
  input  logic [3:0]       req1_op,
  input  logic             req1_s,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [ANCHO-1:0] resp0_resultado,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [ANCHO-1:0] resp1_resultado,
  output logic [ANCHO-1:0] alu_a,
  output logic [ANCHO-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [ANCHO-1:0] alu_resultado,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_c,
  output logic [3:0]       flags,
  output logic             ocupado
);

  typedef enum logic [1:0] {LIBRE, EJECUTAR, RESPONDER} estado_t;

  estado_t          estado;
  logic             ultimo;
  logic             ganador;
  logic             hayPeticion;
  logic             idReg;
  logic             sReg;
  logic [ANCHO-1:0] aReg;
  logic [ANCHO-1:0] bReg;
  logic [ANCHO-1:0] resReg;
  logic [3:0]       opReg;
  logic [3:0]       flagsReg;

  // With both requesting, the one not granted last wins; otherwise the lone requester.
  always_comb begin
    hayPeticion = req0_valid | req1_valid;
    ganador     = (req0_valid && req1_valid) ? ~ultimo : req1_valid;
  end

  assign req0_ready = ~rst && (estado == LIBRE) && hayPeticion && !ganador;
  assign req1_ready = ~rst && (estado == LIBRE) && hayPeticion && ganador;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= LIBRE;
      ultimo   <= 1'b1;
      idReg    <= 1'b0;
      sReg     <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      opReg    <= '0;
      resReg   <= '0;
      flagsReg <= '0;
    end else begin
      case (estado)
        LIBRE: begin
          if (hayPeticion) begin
            aReg   <= ganador ? req1_a  : req0_a;
            bReg   <= ganador ? req1_b  : req0_b;
            opReg  <= ganador ? req1_op : req0_op;
            sReg   <= ganador ? req1_s  : req0_s;
            idReg  <= ganador;
            ultimo <= ganador;
            estado <= EJECUTAR;
          end
        end
        EJECUTAR: begin
          resReg <= alu_resultado;
          if (sReg) flagsReg <= {alu_n, alu_z, alu_c, alu_v};
          estado <= RESPONDER;
        end
        RESPONDER: begin
          if ((!idReg && resp0_ready) || (idReg && resp1_ready)) estado <= LIBRE;
        end
        default: estado <= LIBRE;
      endcase
    end
  end

  assign alu_a           = aReg;
  assign alu_b           = bReg;
  assign alu_control     = opReg;
  assign resp0_valid     = (estado == RESPONDER) && !idReg;
  assign resp1_valid     = (estado == RESPONDER) && idReg;
  assign resp0_resultado = resReg;
  assign resp1_resultado = resReg;
  assign flags           = flagsReg;
  assign ocupado         = (estado != LIBRE);

endmodule

// File: tb/tb_arbitro_alu.sv
// Scoreboard bench for arbitro_alu at ANCHO=4 with a behavioural ALU in the
// environment and a transaction-level model of grants, results and flags.
module tb_arbitro_alu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic         req0_s, req1_s;
  logic         resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [W-1:0] resp0_resultado, resp1_resultado;
  logic [W-1:0] alu_a, alu_b, alu_resultado;
  logic [3:0]   alu_control, flags;
  logic         alu_n, alu_z, alu_v, alu_c, ocupado;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arbitro_alu #(.ANCHO(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .req1_s(req1_s),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_resultado(resp0_resultado),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_resultado(resp1_resultado),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_resultado(alu_resultado), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .alu_c(alu_c), .flags(flags), .ocupado(ocupado)
  );

  // Returns {result[3:0], N, Z, C, V}.
  function automatic logic [7:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    logic [4:0] t;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a ^ b;
      4'b1000: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[3:0];
        c = t[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'b1001: begin
        t = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = t[3:0];
        c = t[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'b1010: r = {a[3], a[3:1]};
      default: r = ~a;
    endcase
    return {r, r[3], (r == 4'd0), c, v};
  endfunction

  always_comb {alu_resultado, alu_n, alu_z, alu_c, alu_v} = aluRef(alu_a, alu_b, alu_control);

  function automatic void chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endfunction

  typedef struct {
    logic         id;
    logic [W-1:0] res;
  } exp_t;
  exp_t sb[$];

  // Transaction model: one operation in flight at a time.
  logic         mBusy, mLast, mId, mAge, mS;
  logic [W-1:0] mA, mB;
  logic [3:0]   mOp, mFlags;
  logic         mWin;
  logic [7:0]   mRef;

  assign mWin = (req0_valid && req1_valid) ? !mLast : req1_valid;
  assign mRef = aluRef(mA, mB, mOp);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy  <= 1'b0;
      mLast  <= 1'b1;
      mId    <= 1'b0;
      mAge   <= 1'b0;
      mS     <= 1'b0;
      mA     <= '0;
      mB     <= '0;
      mOp    <= '0;
      mFlags <= '0;
      sb.delete();
    end else if (!mBusy) begin
      if (req0_valid || req1_valid) begin
        mBusy <= 1'b1;
        mAge  <= 1'b0;
        mId   <= mWin;
        mLast <= mWin;
        mA    <= mWin ? req1_a  : req0_a;
        mB    <= mWin ? req1_b  : req0_b;
        mOp   <= mWin ? req1_op : req0_op;
        mS    <= mWin ? req1_s  : req0_s;
        sb.push_back('{id: mWin, res: mWin ? aluRef(req1_a, req1_b, req1_op) >> 4
                                           : aluRef(req0_a, req0_b, req0_op) >> 4});
      end
    end else if (!mAge) begin
      mAge <= 1'b1;
      if (mS) mFlags <= mRef[3:0];
    end else if (mId ? resp1_ready : resp0_ready) begin
      mBusy <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) && sb.size() > 0)
      void'(sb.pop_front());
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req0_ready", req0_ready, !mBusy && (req0_valid || req1_valid) && !mWin);
      chk("req1_ready", req1_ready, !mBusy && (req0_valid || req1_valid) && mWin);
      chk("ocupado", ocupado, mBusy);
      chk("flags", flags, mFlags);
      chk("resp0_valid", resp0_valid, mBusy && mAge && !mId);
      chk("resp1_valid", resp1_valid, mBusy && mAge && mId);
      if (mBusy) begin
        chk("alu_a", alu_a, mA);
        chk("alu_b", alu_b, mB);
        chk("alu_control", alu_control, mOp);
      end
      if (resp0_valid || resp1_valid) begin
        if (sb.size() == 0) chk("resp_without_request", 1, 0);
        else begin
          chk("resp_id", resp1_valid, sb[0].id);
          chk("resp0_resultado", resp0_resultado, sb[0].res);
          chk("resp1_resultado", resp1_resultado, sb[0].res);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive0(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic s);
    req0_a = a; req0_b = b; req0_op = op; req0_s = s; req0_valid = 1'b1;
  endtask

  task automatic drive1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic s);
    req1_a = a; req1_b = b; req1_op = op; req1_s = s; req1_valid = 1'b1;
  endtask

  task automatic chkCleared();
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_control", alu_control, 0);
    chk("rst_flags", flags, 0);
    chk("rst_resultado", resp0_resultado, 0);
  endtask

  initial begin
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b1001, 4'b1010, 4'b1111, 4'b0101};
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_s = 0; req1_s = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1 chkCleared();
    req0_valid = 1; req1_valid = 1;
    #1 chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #2 rst = 1'b0;
    cyc(1);

    // AND on requester 0, flags untouched
    drive0(4'b1010, 4'b0110, 4'b0000, 1'b0);
    #1 chk("s1_req0_ready", req0_ready, 1);
    cyc(1); req0_valid = 0;
    cyc(1);
    chk("s1_resp0_valid", resp0_valid, 1);
    chk("s1_resultado", resp0_resultado, 4'b0010);
    chk("s1_resp1_valid", resp1_valid, 0);
    chk("s1_flags", flags, 4'b0000);
    cyc(2);

    // ADD on requester 1 with flag update
    drive1(4'b1010, 4'b0110, 4'b1000, 1'b1);
    cyc(1); req1_valid = 0;
    cyc(1);
    chk("s2_resultado", resp1_resultado, 4'b0000);
    chk("s2_flags", flags, 4'b0110);
    cyc(2);

    // Both held: strict alternation starting from requester 1 after it won last
    drive0(4'b0011, 4'b0101, 4'b0001, 1'b0);
    drive1(4'b1100, 4'b1010, 4'b0010, 1'b0);
    cyc(6);
    #1 chk("s3_req0_again", req0_ready, 1);
    chk("s3_req1_waits", req1_ready, 0);
    cyc(1); req0_valid = 0; req1_valid = 0;
    cyc(3);

    // SUB with response back-pressure
    resp0_ready = 1'b0;
    drive0(4'b1010, 4'b0110, 4'b1001, 1'b0);
    cyc(1); req0_valid = 0;
    drive1(4'b0001, 4'b0001, 4'b1000, 1'b1);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("s4_resp0_valid", resp0_valid, 1);
      chk("s4_resultado", resp0_resultado, 4'b0100);
      chk("s4_flags", flags, 4'b0110);
      cyc(1);
    end
    req1_valid = 0; resp0_ready = 1'b1;
    cyc(3);

    // Arithmetic shift right
    drive0(4'b1010, 4'b0000, 4'b1010, 1'b1);
    cyc(1); req0_valid = 0;
    cyc(1);
    chk("s5_resultado", resp0_resultado, 4'b1101);
    chk("s5_flagN", flags[3], 1);
    chk("s5_flagZ", flags[2], 0);
    cyc(2);

    // Reset while executing
    drive0(4'b0111, 4'b0001, 4'b1000, 1'b1);
    cyc(1); req0_valid = 0;
    rst = 1'b1;
    #1 chkCleared();
    req0_valid = 1; req1_valid = 1;
    #1 chk("s6_rst_req0_ready", req0_ready, 0);
    chk("s6_rst_req1_ready", req1_ready, 0);
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("s6_req0_first", req0_ready, 1);
    chk("s6_req1_waits", req1_ready, 0);
    cyc(1); req0_valid = 0; req1_valid = 0;
    cyc(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      req0_op = ops[$urandom_range(0, 7)];
      req1_op = ops[$urandom_range(0, 7)];
      req0_s = 1'($urandom_range(0, 1));
      req1_s = 1'($urandom_range(0, 1));
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    req0_valid = 0; req1_valid = 0; resp0_ready = 1'b1; resp1_ready = 1'b1;
    cyc(6);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
